// File: rtl/key_encoder_83.sv
// key_encoder_83
//   Debounced 8-to-3 priority encoder for active-low push-keys. The raw key
//   lines are brought into the clock domain by a two-flop synchroniser. A
//   four-state FSM accepts a key only after it has been stable for
//   DEBOUNCE_CYCLES cycles. The accepted key is then reported as a 3-bit code.
//   The encoder also produces a level-valid and one-cycle press/release strobes.
//
// Ports
//   clk     in   1  system clock, rising edge
//   rst     in   1  asynchronous reset, active low
//   enable  in   1  1 = encoder active, 0 = FSM forced to IDLE
//   keys_n  in   8  raw key lines, active low, asynchronous to clk
//   code    out  3  index of the accepted key (bit 0 = highest priority)
//   valid   out  1  high while an accepted key is held (HELD, DEB_REL)
//   press   out  1  one-cycle strobe when a press is accepted
//   rel     out  1  one-cycle strobe when a release is accepted
//                   ("release" is a reserved word, hence the short name)
//   any_n   out  1  low when any synchronised key is low (undebounced)
module key_encoder_83 #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] keys_n,
  output logic [2:0] code,
  output logic       valid,
  output logic       press,
  output logic       rel,
  output logic       any_n
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Index of the lowest-numbered low bit; bit 0 wins.
  function automatic logic [2:0] prio_enc(input logic [7:0] k_n);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!k_n[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [7:0]       sync_p0;
  logic [7:0]       keys_s;
  logic             any;
  logic [2:0]       enc;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       cand, cand_nxt;
  logic [2:0]       code_nxt;
  logic             valid_nxt, press_nxt, rel_nxt;

  // Stage p0 -> keys_s: two-flop synchroniser. any_n is registered from the
  // first stage so that it lines up exactly with keys_s without a comb path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 8'hFF;
      keys_s  <= 8'hFF;
      any_n   <= 1'b1;
    end else begin
      sync_p0 <= keys_n;
      keys_s  <= sync_p0;
      any_n   <= &sync_p0;
    end
  end

  assign any = ~&keys_s;
  assign enc = prio_enc(keys_s);

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= 3'd0;
      code  <= 3'd0;
      valid <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
      code  <= code_nxt;
      valid <= valid_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

  // Next-state logic. A press debounce aborts if the winning key changes, so
  // a roll from one key to another always restarts the full debounce.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state_nxt = DEB_PRESS;
            cand_nxt  = enc;
            cnt_nxt   = '0;
          end
        end
        DEB_PRESS: begin
          if (!any || (enc != cand)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        HELD: begin
          // Other keys changing while something stays low are ignored.
          if (!any) begin
            state_nxt = DEB_REL;
            cnt_nxt   = '0;
          end
        end
        DEB_REL: begin
          if (any) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output logic. Strobes fire only on the accepting transitions; a disable
  // out of DEB_REL also lands in IDLE, so it is excluded explicitly.
  always_comb begin
    code_nxt  = code;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    if ((state == DEB_PRESS) && (state_nxt == HELD)) begin
      press_nxt = 1'b1;
      code_nxt  = cand;
    end
    if (enable && (state == DEB_REL) && (state_nxt == IDLE)) begin
      rel_nxt = 1'b1;
    end
    valid_nxt = (state_nxt == HELD) || (state_nxt == DEB_REL);
  end

endmodule

// File: tb/tb_key_encoder_83.sv
// Testbench for key_encoder_83 (DEBOUNCE_CYCLES = 4).
// A run-length reference model predicts press/release events. The model
// pushes each predicted event into a queue, and a monitor pops the queue
// whenever the DUT strobes. The monitor also checks valid/any_n/code every
// cycle.
module tb_key_encoder_83;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] keys_n;
  logic [2:0] code;
  logic       valid, press, rel, any_n;

  key_encoder_83 #(.DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .keys_n (keys_n),
    .code   (code),
    .valid  (valid),
    .press  (press),
    .rel    (rel),
    .any_n  (any_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_rel;
    logic [2:0] code;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  // Reference model state: key samples delayed by two edges, whether a key is
  // accepted, and the lengths of the current qualifying press/release runs.
  logic [7:0] m_s1, m_ks;
  bit         m_held;
  int         m_prun, m_rrun;
  logic [2:0] m_cand, m_code;

  // Lowest-numbered pressed key, or -1 when none is pressed.
  function automatic int low_zero(input logic [7:0] k);
    for (int i = 0; i < 8; i++) begin
      if (!k[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic match(input bit is_rel);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected cyc=%0d code=%0d required=no strobe",
               is_rel ? "release" : "press", cyc, code);
    end else begin
      e = exp_q.pop_front();
      if ((e.is_rel != is_rel) || (e.code !== code) || (e.cyc != cyc)) begin
        errors++;
        $display("FAIL strobe actual: rel=%0d code=%0d cyc=%0d required: rel=%0d code=%0d cyc=%0d",
                 is_rel, code, cyc, e.is_rel, e.code, e.cyc);
      end
    end
  endtask

  // Reference model. A press is accepted once the same key has won
  // D+1 consecutive edges; an edge that breaks the run is lost. A release
  // is accepted after D+1 consecutive edges with no key down.
  always @(posedge clk or negedge rst) begin : model_p
    int  k;
    ev_t ev;
    if (!rst) begin
      m_s1   = 8'hFF;
      m_ks   = 8'hFF;
      m_held = 1'b0;
      m_prun = 0;
      m_rrun = 0;
      m_cand = 3'd0;
      m_code = 3'd0;
      exp_q.delete();
    end else begin
      cyc++;
      k = low_zero(m_ks);
      if (!enable) begin
        m_held = 1'b0;
        m_prun = 0;
        m_rrun = 0;
      end else if (!m_held) begin
        if ((k >= 0) && ((m_prun == 0) || (k == int'(m_cand)))) begin
          if (m_prun == 0) m_cand = 3'(k);
          m_prun++;
          if (m_prun == D + 1) begin
            m_held    = 1'b1;
            m_prun    = 0;
            m_rrun    = 0;
            m_code    = m_cand;
            ev.is_rel = 1'b0;
            ev.code   = m_cand;
            ev.cyc    = cyc;
            exp_q.push_back(ev);
          end
        end else begin
          m_prun = 0;
        end
      end else begin
        if (k < 0) begin
          m_rrun++;
          if (m_rrun == D + 1) begin
            m_held    = 1'b0;
            m_rrun    = 0;
            ev.is_rel = 1'b1;
            ev.code   = m_code;
            ev.cyc    = cyc;
            exp_q.push_back(ev);
          end
        end else begin
          m_rrun = 0;
        end
      end
      m_ks = m_s1;
      m_s1 = keys_n;
    end
  end

  // Monitor
  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("valid", int'(valid), int'(m_held));
      check("any_n", int'(any_n), int'(&m_ks));
      check("code", int'(code), int'(m_code));
      if ((exp_q.size() > 0) && (exp_q[0].cyc < cyc)) begin
        checks++;
        errors++;
        $display("FAIL strobe_missing cyc=%0d actual=none required rel=%0d code=%0d at cyc=%0d",
                 cyc, exp_q[0].is_rel, exp_q[0].code, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (press) match(1'b0);
      if (rel)   match(1'b1);
    end
  end

  task automatic hold(input logic [7:0] k, input int n);
    keys_n = k;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] k;
    rst    = 1'b0;
    enable = 1'b0;
    keys_n = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_code",  int'(code),  0);
    check("rst_valid", int'(valid), 0);
    check("rst_press", int'(press), 0);
    check("rst_rel",   int'(rel),   0);
    check("rst_any_n", int'(any_n), 1);
    rst    = 1'b1;
    enable = 1'b1;
    hold(8'hFF, 2);

    // Single key, then release
    hold(8'hFB, 10);
    hold(8'hFF, 10);
    // Two keys: lower index wins
    hold(8'hF5, 10);
    hold(8'hFF, 10);
    // Bounce shorter than the debounce
    hold(8'hFE, 3);
    hold(8'hFF, 8);
    check("bounce_valid", int'(valid), 0);
    // Release glitch on a held key
    hold(8'hDF, 10);
    hold(8'hFF, 2);
    hold(8'hDF, 6);
    check("glitch_valid", int'(valid), 1);
    hold(8'hFF, 10);
    // Disable while held, then re-enable with the key still down
    hold(8'hFB, 10);
    enable = 1'b0;
    hold(8'hFB, 3);
    enable = 1'b1;
    hold(8'hFB, 10);
    hold(8'hFF, 10);

    // Asynchronous reset in the middle of a press debounce
    keys_n = 8'h7F;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_code",  int'(code),  0);
    check("arst_valid", int'(valid), 0);
    check("arst_press", int'(press), 0);
    check("arst_any_n", int'(any_n), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hold(8'h7F, 12);
    hold(8'hFF, 10);

    // Randomised key patterns and occasional disables
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3:    k = 8'hFF;
        4, 5, 6, 7:    k = ~8'(1 << $urandom_range(0, 7));
        default:       k = 8'($urandom);
      endcase
      enable = ($urandom_range(0, 15) != 0);
      hold(k, $urandom_range(1, 12));
    end

    enable = 1'b1;
    hold(8'hFF, 20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
